// File: rtl/instr_dispatch_fsm.sv
// instr_dispatch_fsm: fetch/decode/dispatch sequencer that owns the PC increment/load path.
// Optional EXEC watchdog enabled by defining DISPATCH_WDT_EN.
module instr_dispatch_fsm #(
    parameter int WDT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    output logic        fetchReq,
    input  logic        fetchAck,
    input  logic [15:0] instrIn,
    output logic [15:0] instr,
    output logic [3:0]  start,
    input  logic [3:0]  done,
    input  logic        branchTaken,
    output logic        pcInc,
    output logic        pcLoad,
    output logic        illegalOp,
    output logic        halted,
    output logic        busy,
    output logic        wdtFault
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, ADVANCE, HALTED} state_t;
    state_t state, state_nx;
    logic [3:0] op;
    logic [1:0] unit, unit_dec;
    logic       first, taken, is_nop, is_halt, is_unit, done_ok, wdt_hit;

    assign op       = instr[15:12];
    assign is_nop   = op == 4'h0;
    assign is_halt  = op == 4'hF;
    assign is_unit  = op == 4'h4 || op == 4'h8 || op == 4'h9 || op == 4'hC;
    assign unit_dec = op == 4'h8 ? 2'd1 : op == 4'h9 ? 2'd2 : op == 4'hC ? 2'd3 : 2'd0;
    // done is only honoured after the start cycle, and only from the launched unit
    assign done_ok  = !first && done[unit];

`ifdef DISPATCH_WDT_EN
    logic [15:0] wdt_cnt;
    assign wdt_hit = {1'b0, wdt_cnt} + 17'd1 == 17'(WDT_CYCLES);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdt_cnt  <= '0;
            wdtFault <= 1'b0;
        end else begin
            wdt_cnt <= state == EXEC ? wdt_cnt + 16'd1 : 16'd0;
            if (state == EXEC && !done_ok && wdt_hit)
                wdtFault <= 1'b1;
        end
    end
`else
    logic [15:0] unused_wdt;
    assign unused_wdt = 16'(WDT_CYCLES);
    assign wdt_hit    = 1'b0;
    assign wdtFault   = 1'b0;
`endif

    always_comb begin
        state_nx  = state;
        fetchReq  = state == FETCH;
        start     = state == EXEC && first ? 4'b0001 << unit : 4'b0000;
        pcInc     = state == ADVANCE && !taken;
        pcLoad    = state == ADVANCE && taken;
        illegalOp = state == DECODE && !is_nop && !is_halt && !is_unit;
        halted    = state == HALTED;
        busy      = state != IDLE && state != HALTED;
        case (state)
            IDLE:    state_nx = run ? FETCH : IDLE;
            FETCH:   state_nx = fetchAck ? DECODE : FETCH;
            DECODE:  state_nx = is_halt ? HALTED : is_unit ? EXEC : ADVANCE;
            EXEC:    state_nx = done_ok ? ADVANCE : wdt_hit ? HALTED : EXEC;
            ADVANCE: state_nx = run ? FETCH : IDLE;
            default: state_nx = HALTED;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            instr <= '0;
            unit  <= '0;
            first <= 1'b0;
            taken <= 1'b0;
        end else begin
            state <= state_nx;
            first <= state == DECODE;
            if (state == FETCH && fetchAck)
                instr <= instrIn;
            if (state == DECODE) begin
                unit  <= unit_dec;
                taken <= 1'b0;
            end
            if (state == EXEC && done_ok && unit == 2'd3)
                taken <= branchTaken;
        end
    end
endmodule

// File: tb/tb_instr_dispatch_fsm.sv
// tb_instr_dispatch_fsm: directed stimulus with an instruction-lifetime reference model
// checked every cycle, plus literal expectations for the documented scenarios.
module tb_instr_dispatch_fsm;
    logic        clk = 0, rst = 0, run = 0, fetchAck = 0, branchTaken = 0;
    logic [15:0] instrIn = 0;
    logic [3:0]  done = 0;
    logic        fetchReq, pcInc, pcLoad, illegalOp, halted, busy, wdtFault;
    logic [15:0] instr;
    logic [3:0]  start;

    instr_dispatch_fsm #(.WDT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .run(run), .fetchReq(fetchReq), .fetchAck(fetchAck),
        .instrIn(instrIn), .instr(instr), .start(start), .done(done),
        .branchTaken(branchTaken), .pcInc(pcInc), .pcLoad(pcLoad), .illegalOp(illegalOp),
        .halted(halted), .busy(busy), .wdtFault(wdtFault)
    );

    always #5 clk = ~clk;

`ifdef DISPATCH_WDT_EN
    localparam bit wdt_on = 1'b1;
`else
    localparam bit wdt_on = 1'b0;
`endif
    localparam int wdt_n = 4;

    int n_chk = 0, n_fail = 0;
    int cyc = 0, n_inc = 0, n_load = 0, n_st = 0, n_ill = 0, n_fr = 0;
    int inc_cyc = 0, st_cyc = 0, ack_cyc = 0;
    logic [3:0] last_start = 0;

    function automatic int unit_of(input logic [3:0] o);
        return o == 4'h4 ? 0 : o == 4'h8 ? 1 : o == 4'h9 ? 2 : o == 4'hC ? 3 : -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: an instruction lives from its ack; age 1 is decode, age 2 the start cycle of a unit,
    // the PC pulse happens at age m_end (2 for NOP/illegal, one past the accepted done for units).
    bit          m_fetch = 0, m_halt = 0, m_fault = 0, m_load = 0;
    int          m_age = 0, m_end = 0, mu;
    logic [15:0] m_instr = 0;
    assign mu = unit_of(m_instr[15:12]);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_fetch <= 0; m_halt <= 0; m_fault <= 0; m_load <= 0;
            m_age <= 0; m_end <= 0; m_instr <= 0;
        end else if (!m_halt) begin
            if (m_fetch) begin
                if (fetchAck) begin
                    m_fetch <= 0;
                    m_age   <= 1;
                    m_instr <= instrIn;
                    m_load  <= 0;
                    m_end   <= (unit_of(instrIn[15:12]) < 0 && instrIn[15:12] != 4'hF) ? 2 : 0;
                end
            end else if (m_age == 0) begin
                m_fetch <= run;
            end else if (m_age == m_end) begin
                m_age   <= 0;
                m_fetch <= run;
            end else if (m_age == 1 && m_instr[15:12] == 4'hF) begin
                m_halt <= 1;
                m_age  <= 0;
            end else if (mu >= 0 && m_end == 0 && m_age >= 3 && done[2'(mu)]) begin
                m_end  <= m_age + 1;
                m_load <= mu == 3 && branchTaken;
                m_age  <= m_age + 1;
            end else if (wdt_on && mu >= 0 && m_end == 0 && m_age - 1 == wdt_n) begin
                m_halt  <= 1;
                m_fault <= 1;
                m_age   <= 0;
            end else begin
                m_age <= m_age + 1;
            end
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        check("cycle", {fetchReq, instr, start, pcInc, pcLoad, illegalOp, halted, busy, wdtFault},
              {m_fetch, m_instr, (m_age == 2 && mu >= 0) ? 4'(1 << mu) : 4'b0000,
               m_age != 0 && m_age == m_end && !m_load, m_age != 0 && m_age == m_end && m_load,
               m_age == 1 && mu < 0 && m_instr[15:12] != 4'h0 && m_instr[15:12] != 4'hF,
               m_halt, m_fetch || m_age != 0, m_fault});
        if (pcInc) begin n_inc++; inc_cyc = cyc; end
        if (pcLoad) n_load++;
        if (|start) begin n_st++; last_start = start; st_cyc = cyc; end
        if (illegalOp) n_ill++;
        if (fetchReq) n_fr++;
        if (fetchReq && fetchAck) ack_cyc = cyc;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fetch;
        for (int i = 0; i < 20 && !fetchReq; i++) tick;
        check("fetch_wait", fetchReq, 1);
    endtask

    task automatic do_instr(input logic [15:0] w, input int dly, input logic tk,
                            input logic [3:0] sp0, input logic [3:0] sp1);
        int u;
        u = unit_of(w[15:12]);
        wait_fetch;
        fetchAck = 1; instrIn = w;
        tick;
        fetchAck = 0;
        tick;
        if (u >= 0) begin
            done = sp0;
            for (int k = 1; k < dly; k++) begin tick; done = sp1; end
            tick;
            done = 4'(1 << u); branchTaken = tk;
            tick;
            done = 0; branchTaken = 0;
        end
        tick;
    endtask

    task automatic do_reset;
        rst = 1;
        tick;
        tick;
        rst = 0;
    endtask

    int b_inc, b_load, b_st, b_ill, b_fr;
    task automatic base;
        b_inc = n_inc; b_load = n_load; b_st = n_st; b_ill = n_ill; b_fr = n_fr;
    endtask

    initial begin
        #1 rst = 1;
        #2 check("reset_outputs", {fetchReq, instr, start, pcInc, pcLoad, illegalOp, halted, busy, wdtFault}, 0);
        tick;
        rst = 0; run = 1;
        // MOV with done three cycles after start
        base;
        do_instr(16'h4042, 3, 0, 0, 0);
        check("mov_instr", instr, 16'h4042);
        check("mov_start_val", last_start, 4'b0001);
        check("mov_start_cnt", n_st - b_st, 1);
        check("mov_pcinc_cnt", n_inc - b_inc, 1);
        check("mov_fetch_back", fetchReq, 1);
        // NOP: pcInc two cycles after ack
        base;
        do_instr(16'h0000, 0, 0, 0, 0);
        check("nop_no_start", n_st - b_st, 0);
        check("nop_inc_latency", inc_cyc - ack_cyc, 2);
        // BRANCH taken / not taken
        base;
        do_instr(16'hC005, 1, 1, 0, 0);
        check("br_taken_load", n_load - b_load, 1);
        check("br_taken_inc", n_inc - b_inc, 0);
        base;
        do_instr(16'hC005, 1, 0, 0, 0);
        check("br_nt_load", n_load - b_load, 0);
        check("br_nt_inc", n_inc - b_inc, 1);
        // illegal then HALT
        base;
        do_instr(16'h2000, 0, 0, 0, 0);
        check("ill_pulse", n_ill - b_ill, 1);
        check("ill_no_start", n_st - b_st, 0);
        check("ill_inc", n_inc - b_inc, 1);
        base;
        do_instr(16'hF000, 0, 0, 0, 0);
        b_fr = n_fr;
        repeat (10) tick;
        check("halt_level", {halted, busy}, 2'b10);
        check("halt_no_fetch", n_fr - b_fr, 0);
        check("halt_no_pc", (n_inc - b_inc) + (n_load - b_load), 0);
        check("halt_instr", instr, 16'hF000);
        // LOAD with spurious dones in start and exec cycles
        do_reset;
        base;
        do_instr(16'h8000, 2, 0, 4'b1111, 4'b0100);
        check("load_start_cnt", n_st - b_st, 1);
        check("load_exec_len", inc_cyc - st_cyc, 3);
        check("load_inc", n_inc - b_inc, 1);
        // reset while in EXEC
        wait_fetch;
        fetchAck = 1; instrIn = 16'h9000;
        tick;
        fetchAck = 0;
        tick;
        tick;
        #2 rst = 1;
        #1 check("rst_mid_exec", {fetchReq, instr, start, pcInc, pcLoad, illegalOp, halted, busy, wdtFault}, 0);
        tick;
        rst = 0;
        // ALU whose done never arrives
        base;
        wait_fetch;
        fetchAck = 1; instrIn = 16'h4001;
        tick;
        fetchAck = 0;
        tick;
`ifdef DISPATCH_WDT_EN
        repeat (6) tick;
        check("wdt_fault", {wdtFault, halted, busy}, 3'b110);
`else
        repeat (100) tick;
        check("no_wdt_wait", {wdtFault, halted, busy}, 3'b001);
`endif
        check("wait_no_inc", n_inc - b_inc, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
